// File: rtl/aexm_pkg.sv
// Shared aexm definitions: opcodes, multi-cycle datapath op encoding, scheduler states.
package aexm_pkg;

  localparam logic [5:0] OPC_MUL  = 6'o20;
  localparam logic [5:0] OPC_MULI = 6'o30;
  localparam logic [5:0] OPC_BSF  = 6'o21;
  localparam logic [5:0] OPC_BSFI = 6'o31;
  localparam logic [5:0] OPC_DIV  = 6'o22;

  typedef enum logic [1:0] {
    MDU_NONE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_BSF  = 2'd2,
    MDU_DIV  = 2'd3
  } mduOp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mcycState_t;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/aexm_mcyc_dec.sv
// Combinational multi-cycle opcode decoder; also feeds the hazard logic.
module aexm_mcyc_dec
  import aexm_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int BSF_CYCLES = 1,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic [5:0]       opc,
  output logic [1:0]       op,
  output logic [CNT_W-1:0] cycles
);

  always_comb begin
    op     = MDU_NONE;
    cycles = '0;
    case (opc)
      OPC_MUL, OPC_MULI: begin
        op     = MDU_MUL;
        cycles = CNT_W'(MUL_CYCLES);
      end
      OPC_BSF, OPC_BSFI: begin
        op     = MDU_BSF;
        cycles = CNT_W'(BSF_CYCLES);
      end
      OPC_DIV: begin
        op     = MDU_DIV;
        cycles = CNT_W'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/aexm_mcyc_ctrl.sv
// Multi-cycle execute scheduler: freezes decode/execute while MUL/BSF/DIV iterate
// and holds interrupts off until the operation retires.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | pipeline flows; watch for multi-cycle issue or interrupt
//   ST_RUN  | pipeline frozen; datapath stepping, counter counts down
//   ST_DONE | instruction retires; presented opcode is ignored
module aexm_mcyc_ctrl
  import aexm_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int BSF_CYCLES = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic       gclk,
  input  logic       grst,
  input  logic       sys_en,
  input  logic       iss_valid,
  input  logic [5:0] iss_opc,
  input  logic       cpu_interrupt,
  output logic       d_en,
  output logic       x_en,
  output logic [1:0] mdu_op,
  output logic       mdu_start,
  output logic       mdu_step,
  output logic       mdu_last,
  output logic       mdu_busy,
  output logic       int_take
);

  localparam int MAX_N = maxOf3(MUL_CYCLES, BSF_CYCLES, DIV_CYCLES);
  localparam int CNT_W = $clog2(MAX_N + 1);

  mcycState_t       state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  mduOp_t           mduOp, mduOpNxt;
  logic             intPend, intPendNxt;

  logic [1:0]       decOp;
  logic [CNT_W-1:0] decN;
  logic             intReq, mcIssue;
  logic             pipeEn, start, step, last, take;

  aexm_mcyc_dec #(
    .MUL_CYCLES(MUL_CYCLES),
    .BSF_CYCLES(BSF_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) uDec (
    .opc   (iss_opc),
    .op    (decOp),
    .cycles(decN)
  );

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      mduOp   <= MDU_NONE;
      intPend <= 1'b0;
    end else begin
      state   <= stateNxt;
      cnt     <= cntNxt;
      mduOp   <= mduOpNxt;
      intPend <= intPendNxt;
    end
  end

  assign intReq  = cpu_interrupt | intPend;
  assign mcIssue = iss_valid & sys_en & ~intReq & (decOp != MDU_NONE);

  always_comb begin
    stateNxt   = state;
    cntNxt     = cnt;
    mduOpNxt   = mduOp;
    intPendNxt = intPend;
    pipeEn     = 1'b0;
    start      = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    take       = 1'b0;
    case (state)
      ST_IDLE: begin
        pipeEn = sys_en;
        // An interrupt beats a simultaneous multi-cycle issue.
        if (intReq && sys_en) begin
          take       = 1'b1;
          intPendNxt = 1'b0;
        end else if (mcIssue) begin
          start    = 1'b1;
          pipeEn   = 1'b0;
          mduOpNxt = mduOp_t'(decOp);
          cntNxt   = decN - CNT_W'(1);
          stateNxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step = sys_en;
        if (step) begin
          if (cnt == '0) begin
            last     = 1'b1;
            mduOpNxt = MDU_NONE;
            stateNxt = ST_DONE;
          end else begin
            cntNxt = cnt - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        pipeEn = sys_en;
        if (sys_en) stateNxt = ST_IDLE;
      end
      default: stateNxt = ST_IDLE;
    endcase
    if (sys_en && cpu_interrupt && state != ST_IDLE) intPendNxt = 1'b1;
  end

  // Strobes are combinational, so reset must mask them explicitly.
  assign d_en      = pipeEn & grst;
  assign x_en      = pipeEn & grst;
  assign mdu_start = start & grst;
  assign mdu_step  = step & grst;
  assign mdu_last  = last & grst;
  assign int_take  = take & grst;
  assign mdu_op    = mduOp;
  assign mdu_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_aexm_mcyc_ctrl.sv
// Scoreboard bench for aexm_mcyc_ctrl: a cycle-level reference model queues the
// expected output vector for every driven cycle; the sampled DUT output pops it.
module tb_aexm_mcyc_ctrl;

  logic       gclk = 1'b0;
  logic       grst = 1'b0;
  logic       sys_en = 1'b0;
  logic       iss_valid = 1'b0;
  logic [5:0] iss_opc = 6'o00;
  logic       cpu_interrupt = 1'b0;
  logic       d_en, x_en, mdu_start, mdu_step, mdu_last, mdu_busy, int_take;
  logic [1:0] mdu_op;

  always #5 gclk = ~gclk;

  aexm_mcyc_ctrl dut (
    .gclk         (gclk),
    .grst         (grst),
    .sys_en       (sys_en),
    .iss_valid    (iss_valid),
    .iss_opc      (iss_opc),
    .cpu_interrupt(cpu_interrupt),
    .d_en         (d_en),
    .x_en         (x_en),
    .mdu_op       (mdu_op),
    .mdu_start    (mdu_start),
    .mdu_step     (mdu_step),
    .mdu_last     (mdu_last),
    .mdu_busy     (mdu_busy),
    .int_take     (int_take)
  );

  int nPass = 0;
  int nChk  = 0;
  string curTag = "reset";
  logic [8:0] expQ[$];

  // Reference model: phase 0 idle, 1 running, 2 done; mLeft = steps still owed.
  int         mPhase = 0;
  int         mLeft = 0;
  logic [1:0] mOp = 2'd0;
  logic       mPend = 1'b0;

  int tSteps, tDlow, tStart, tTake;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void benchDec(input logic [5:0] o, output logic [1:0] op, output int n);
    case (o)
      6'o20, 6'o30: begin op = 2'd1; n = 2;  end
      6'o21, 6'o31: begin op = 2'd2; n = 1;  end
      6'o22:        begin op = 2'd3; n = 32; end
      default:      begin op = 2'd0; n = 0;  end
    endcase
  endfunction

  // Returns expected {d_en,x_en,mdu_op,start,step,last,busy,int_take}, advances model.
  function automatic logic [8:0] model(input logic r, input logic se, input logic v,
                                       input logic [5:0] o, input logic irq);
    logic       dE, st, sp, la, bz, tk, req;
    logic [1:0] op, newOp;
    int         n;
    dE = 0; st = 0; sp = 0; la = 0; tk = 0;
    if (!r) begin
      mPhase = 0; mLeft = 0; mOp = 2'd0; mPend = 1'b0;
      return 9'd0;
    end
    op = mOp;
    bz = (mPhase != 0);
    benchDec(o, newOp, n);
    if (mPhase == 0) begin
      req = irq | mPend;
      tk  = req & se;
      st  = v & se & ~req & (newOp != 2'd0);
      dE  = se & ~st;
      if (tk) mPend = 1'b0;
      if (st) begin mPhase = 1; mLeft = n; mOp = newOp; end
    end else if (mPhase == 1) begin
      sp = se;
      la = sp && (mLeft == 1);
      if (irq && se) mPend = 1'b1;
      if (sp) begin
        mLeft--;
        if (mLeft == 0) begin mPhase = 2; mOp = 2'd0; end
      end
    end else begin
      dE = se;
      if (irq && se) mPend = 1'b1;
      if (se) mPhase = 0;
    end
    return {dE, dE, op, st, sp, la, bz, tk};
  endfunction

  task automatic cyc(input logic r, input logic se, input logic v, input logic [5:0] o,
                     input logic irq);
    logic [8:0] obs;
    @(posedge gclk);
    #1;
    grst = r; sys_en = se; iss_valid = v; iss_opc = o; cpu_interrupt = irq;
    expQ.push_back(model(r, se, v, o, irq));
    @(negedge gclk);
    obs = {d_en, x_en, mdu_op, mdu_start, mdu_step, mdu_last, mdu_busy, int_take};
    chk(curTag, obs, expQ.pop_front());
    tSteps += mdu_step;
    tStart += mdu_start;
    tTake  += int_take;
    if (grst && !d_en) tDlow++;
  endtask

  task automatic clrTally();
    tSteps = 0; tDlow = 0; tStart = 0; tTake = 0;
  endtask

  initial begin
    logic [5:0] opcs[7];
    opcs = '{6'o00, 6'o20, 6'o30, 6'o21, 6'o31, 6'o22, 6'o17};

    curTag = "reset";
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 6'o22, 1);
    cyc(1, 1, 0, 6'o00, 0);

    curTag = "single_cycle";
    clrTally();
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 6'o00, 0);
    chk("single_cycle_starts", tStart, 0);
    chk("single_cycle_dlow", tDlow, 0);

    curTag = "div";
    clrTally();
    for (int i = 0; i < 34; i++) cyc(1, 1, 1, 6'o22, 0);
    cyc(1, 1, 0, 6'o00, 0);
    chk("div_steps", tSteps, 32);
    chk("div_dlow", tDlow, 33);
    chk("div_starts", tStart, 1);

    curTag = "bsf_freeze";
    clrTally();
    cyc(1, 1, 1, 6'o21, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 6'o21, 0);
    cyc(1, 1, 1, 6'o21, 0);
    cyc(1, 1, 1, 6'o21, 0);
    cyc(1, 1, 0, 6'o00, 0);
    chk("bsf_steps", tSteps, 1);
    chk("bsf_dlow", tDlow, 5);

    curTag = "div_irq";
    clrTally();
    for (int i = 0; i < 40; i++) cyc(1, 1, (i < 34), 6'o22, (i == 5));
    chk("div_irq_takes", tTake, 1);

    curTag = "irq_vs_issue";
    clrTally();
    cyc(1, 1, 1, 6'o20, 1);
    cyc(1, 1, 1, 6'o20, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 6'o20, 0);
    cyc(1, 1, 0, 6'o00, 0);
    chk("irq_vs_issue_takes", tTake, 1);

    curTag = "back_to_back";
    clrTally();
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 6'o30, 0);
    cyc(1, 1, 0, 6'o00, 0);
    chk("back_to_back_starts", tStart, 3);

    curTag = "reset_mid_div";
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 6'o22, 0);
    cyc(0, 1, 1, 6'o22, 0);
    cyc(0, 1, 1, 6'o22, 0);
    cyc(1, 1, 0, 6'o00, 0);
    cyc(1, 1, 0, 6'o00, 0);

    curTag = "random";
    for (int i = 0; i < 400; i++)
      cyc(1, ($urandom_range(99) < 80), $urandom_range(1), opcs[$urandom_range(6)],
          ($urandom_range(99) < 5));

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/aexm_mcyc_ctrl.md
# aexm_mcyc_ctrl

Multi-cycle execute scheduler for the aexm core. Detects multi-cycle opcodes (MUL, BSF, DIV) entering execute, freezes the decode/execute pipeline enables, and sequences the iterative MUL/BSF/DIV datapath with start/step/last strobes. Defers interrupts until the operation retires. Sits between the instruction decode/control logic and the pipeline-enable fan-out that drives `d_en`/`x_en`.

## Interface
Parameters:
- `MUL_CYCLES`, default 2, datapath cycles for MUL (≥1)
- `BSF_CYCLES`, default 1, datapath cycles for BSF (≥1)
- `DIV_CYCLES`, default 32, datapath cycles for DIV (≥1)

Ports:
- `gclk` in 1: the block's only clock.
- `grst` in 1: reset, **asynchronous, active-low**.
- `sys_en` in 1: global enable from the memory side; low = whole core frozen.
- `iss_valid` in 1: an instruction is presented to execute this cycle.
- `iss_opc` in 6: opcode of that instruction.
- `cpu_interrupt` in 1: interrupt request, level.
- `d_en` out 1: decode-stage enable.
- `x_en` out 1: execute-stage enable.
- `mdu_op` out 2: operation code; 0 none, 1 MUL, 2 BSF, 3 DIV. Held for the whole operation.
- `mdu_start` out 1: one-cycle pulse that loads the datapath operands.
- `mdu_step` out 1: iterate the datapath this cycle.
- `mdu_last` out 1: final step.
- `mdu_busy` out 1: FSM not IDLE.
- `int_take` out 1: one-cycle pulse; the interrupt may be converted to a branch.

## Operation
- **Decode**, with `mc = iss_valid & sys_en & !int_req`:
  - MUL = opc 6'o20 or 6'o30.
  - BSF = opc 6'o21 or 6'o31.
  - DIV = opc 6'o22.
  - `N` = the parameter for the decoded op.
- **State machine**: IDLE, RUN, DONE.
- **IDLE**
  - `d_en = x_en = sys_en`.
  - If `mc` with a multi-cycle op:
    - `mdu_start = 1` and `d_en = x_en = 0` (combinational, same cycle).
    - Latch `mdu_op`; load counter with N-1; go to RUN.
- **RUN**
  - `d_en = x_en = 0`.
  - `mdu_step = sys_en`.
  - Counter decrements on each step.
  - `mdu_last = mdu_step & (cnt == 0)`; on `mdu_last`, go to DONE.
- **DONE**
  - `d_en = x_en = sys_en` (the instruction retires).
  - `iss_valid` is ignored in this state, because the same instruction is still presented.
  - `mdu_op` is cleared; go to IDLE when `sys_en`.
- **Counter**: width = clog2(max(N)+1); it never wraps because decrement is gated by `cnt != 0`.
- **sys_en low**
  - State, counter and the pending latch all hold.
  - `mdu_step`, `mdu_start` and `int_take` are forced to 0.
  - `d_en` and `x_en` are 0.
- **Interrupts**
  - `int_req = cpu_interrupt | int_pend`.
  - `int_pend` is set when `cpu_interrupt` is high while `mdu_busy`.
  - `int_take = int_req & sys_en & IDLE`. It clears `int_pend`.
  - If `int_req` and a multi-cycle issue occur in the same IDLE cycle, the interrupt wins: `int_take` pulses and no start occurs.
- **Reset**, asynchronous, including mid-operation:
  - State IDLE, counter 0, `mdu_op` 0, `int_pend` 0.
  - All outputs 0 while `grst` is low, including `d_en` and `x_en`.
  - No partial operation resumes after reset.

## Timing
- **Single-cycle op**: no effect; `d_en`/`x_en` follow `sys_en`.
- **Multi-cycle op** issued in cycle t, with `sys_en` held high:
  - `mdu_start` at t.
  - `mdu_step` at t+1 … t+N.
  - `mdu_last` at t+N.
  - DONE at t+N+1.
  - `d_en`/`x_en` are low for exactly N+1 cycles (t … t+N) and high again at t+N+1.
- **Stretching**: each cycle with `sys_en` low in RUN or DONE extends the sequence by one cycle and produces no step.
- **Back-to-back multi-cycle ops**: the second may start at the earliest at t+N+2 (the first IDLE cycle after DONE).
- **Deferred interrupt**: `int_take` comes no earlier than the first IDLE cycle after DONE.
- **Register boundary**:
  - `mdu_op`, state and counter are registered.
  - `mdu_start`, `mdu_step`, `mdu_last`, `d_en`, `x_en` and `int_take` are combinational from state and inputs.

## Structure
- Shared package `aexm_pkg` holds:
  - Opcode constants `OPC_MUL`, `OPC_MULI`, `OPC_BSF`, `OPC_BSFI`, `OPC_DIV`.
  - The `mdu_op` encoding.
  - The FSM state encoding.
- One sub-module, `aexm_mcyc_dec`: a combinational opcode decoder returning the op code and N. It is reused by the hazard logic.
- The counter and FSM stay in the top module.

## Test plan
- **DIV, default parameters**: `iss_opc`=6'o22, `sys_en`=1 → `mdu_start` at t, 32 `mdu_step` pulses, `mdu_last` at t+32, `d_en` low for 33 cycles, `mdu_op`=3 throughout.
- **BSF with mid-operation freeze**: BSF issue, then `sys_en`=0 for 3 cycles during RUN → step delayed by 3 cycles, `d_en` low for 5 cycles, no duplicate step.
- **Interrupt during DIV**: `cpu_interrupt` pulses for 1 cycle at t+5 of a DIV → no `int_take` while busy; `int_take` exactly once in the first IDLE cycle after DONE.
- **Simultaneous interrupt and issue**: `cpu_interrupt`=1 and MUL issue in the same IDLE cycle → `int_take`=1, `mdu_start`=0, state stays IDLE.
- **Reset mid-operation**: `grst` low at t+10 of a DIV → all outputs 0 immediately; after release, IDLE with `d_en`=1 and `mdu_op`=0.
- **Non-multi-cycle opcode**: `iss_opc`=6'o00 for 10 cycles → `d_en`=`x_en`=1, no strobes.
